// File: rtl/osc_mixer_if.sv
// Bus between the wave loader / output stage and osc_mixer.
// The slave modport is the mixer's view; the master modport drives samples and ticks.
interface osc_mixer_if #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int SHIFT_WIDTH     = 4
);
  logic                                            sample_tick_in;
  logic [NUM_OSCILLATORS-1:0]                      osc_is_on_in;
  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]    osc_data_in;
  logic [SHIFT_WIDTH-1:0]                          shift_in;
  logic [SAMPLE_WIDTH-1:0]                         mix_data_out;
  logic                                            mix_valid_out;
  logic                                            busy_out;
  logic [7:0]                                      overrun_count_out;

  modport master (
    output sample_tick_in, osc_is_on_in, osc_data_in, shift_in,
    input  mix_data_out, mix_valid_out, busy_out, overrun_count_out
  );

  modport slave (
    input  sample_tick_in, osc_is_on_in, osc_data_in, shift_in,
    output mix_data_out, mix_valid_out, busy_out, overrun_count_out
  );
endinterface

// File: rtl/osc_mixer.sv
// Serial oscillator mixer: snapshot on tick, accumulate one oscillator per clock,
// then arithmetic-shift, saturate and emit one sample with a single-cycle valid.
module osc_mixer #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int SHIFT_WIDTH     = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  osc_mixer_if.slave bus
);
  localparam int IDX_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
  localparam int ACC_W = SAMPLE_WIDTH + $clog2(NUM_OSCILLATORS) + 1;
  localparam int EXT_W = ACC_W - SAMPLE_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                                       state_q, state_d;
  logic signed [ACC_W-1:0]                      acc_q, acc_d;
  logic [IDX_W-1:0]                             idx_q, idx_d;
  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] data_snap_q, data_snap_d;
  logic [NUM_OSCILLATORS-1:0]                   on_snap_q, on_snap_d;
  logic [SHIFT_WIDTH-1:0]                       shift_snap_q, shift_snap_d;
  logic [SAMPLE_WIDTH-1:0]                      mix_data_q, mix_data_d;
  logic                                         mix_valid_q, mix_valid_d;
  logic [7:0]                                   ovr_q, ovr_d;
  logic                                         take_snap;

  logic signed [ACC_W-1:0]                      term [NUM_OSCILLATORS];
  logic signed [ACC_W-1:0]                      scaled;
  logic [ACC_W-SAMPLE_WIDTH:0]                  upper;
  logic [SAMPLE_WIDTH-1:0]                      sat_data;

  // Disabled oscillators contribute zero; enabled ones are sign-extended.
  generate
    for (genvar gi = 0; gi < NUM_OSCILLATORS; gi++) begin : g_term
      assign term[gi] = on_snap_q[gi]
                      ? {{EXT_W{data_snap_q[gi][SAMPLE_WIDTH-1]}}, data_snap_q[gi]}
                      : '0;
    end
  endgenerate

  // Result fits when every bit above the output sign bit equals that sign bit.
  assign scaled = acc_q >>> shift_snap_q;
  assign upper  = scaled[ACC_W-1:SAMPLE_WIDTH-1];

  always_comb begin
    sat_data = scaled[SAMPLE_WIDTH-1:0];
    if (!((&upper) || !(|upper))) begin
      sat_data = scaled[ACC_W-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                 : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    data_snap_d  = data_snap_q;
    on_snap_d    = on_snap_q;
    shift_snap_d = shift_snap_q;
    mix_data_d   = mix_data_q;
    mix_valid_d  = 1'b0;
    ovr_d        = ovr_q;
    take_snap    = 1'b0;

    case (state_q)
      IDLE: begin
        take_snap = bus.sample_tick_in;
      end
      ACCUM: begin
        acc_d = acc_q + term[idx_q];
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_OSCILLATORS - 1)) begin
          state_d = OUTPUT;
        end
        if (bus.sample_tick_in && (ovr_q != 8'hFF)) begin
          ovr_d = ovr_q + 8'd1;
        end
      end
      OUTPUT: begin
        mix_data_d  = sat_data;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
        take_snap   = bus.sample_tick_in;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_snap) begin
      data_snap_d  = bus.osc_data_in;
      on_snap_d    = bus.osc_is_on_in;
      shift_snap_d = bus.shift_in;
      acc_d        = '0;
      idx_d        = '0;
      state_d      = ACCUM;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      data_snap_q  <= '0;
      on_snap_q    <= '0;
      shift_snap_q <= '0;
      mix_data_q   <= '0;
      mix_valid_q  <= 1'b0;
      ovr_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      data_snap_q  <= data_snap_d;
      on_snap_q    <= on_snap_d;
      shift_snap_q <= shift_snap_d;
      mix_data_q   <= mix_data_d;
      mix_valid_q  <= mix_valid_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.mix_data_out      = mix_data_q;
  assign bus.mix_valid_out     = mix_valid_q;
  assign bus.busy_out          = (state_q != IDLE);
  assign bus.overrun_count_out = ovr_q;
endmodule

// File: tb/tb_osc_mixer.sv
// Scoreboard bench for osc_mixer: expected mixes are queued at tick time and
// popped by a monitor whenever the mixer raises its valid pulse.
module tb_osc_mixer;
  localparam int N    = 4;
  localparam int SW   = 16;
  localparam int SHW  = 4;
  localparam int SMAX = (1 << (SW - 1)) - 1;
  localparam int SMIN = -(1 << (SW - 1));

  typedef logic [N-1:0][SW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  osc_mixer_if #(.NUM_OSCILLATORS(N), .SAMPLE_WIDTH(SW), .SHIFT_WIDTH(SHW)) bus ();

  osc_mixer #(.NUM_OSCILLATORS(N), .SAMPLE_WIDTH(SW), .SHIFT_WIDTH(SHW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_valid = -1;
  bit          mon_en = 1'b1;
  bit          b2b_chk = 1'b0;
  logic [SW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input logic [SW-1:0] a, input logic [SW-1:0] b,
                              input logic [SW-1:0] c, input logic [SW-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [SW-1:0] model(input vec_t d, input logic [N-1:0] on,
                                         input logic [SHW-1:0] sh);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      if (on[i]) s += int'($signed(d[i]));
    end
    s = s >>> sh;
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    return s[SW-1:0];
  endfunction

  task automatic scramble();
    bus.osc_data_in  = vec_t'({$urandom(), $urandom()});
    bus.osc_is_on_in = N'($urandom());
    bus.shift_in     = SHW'($urandom());
  endtask

  // Called at a negedge; returns at the negedge after the tick-sampling edge.
  task automatic send(input vec_t d, input logic [N-1:0] on, input logic [SHW-1:0] sh,
                      input logic [SW-1:0] e);
    bus.osc_data_in    = d;
    bus.osc_is_on_in   = on;
    bus.shift_in       = sh;
    bus.sample_tick_in = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.sample_tick_in = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy_out) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en && bus.mix_valid_out) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(bus.mix_valid_out), 32'd0);
      end else begin
        logic [SW-1:0] e;
        e = exp_q.pop_front();
        $display("mix cycle %0d: out 0x%h exp 0x%h", cyc, bus.mix_data_out, e);
        check_eq("mix_data", 32'(bus.mix_data_out), 32'(e));
        if (b2b_chk && last_valid >= 0) check_eq("b2b_period", 32'(cyc - last_valid), 32'd5);
        last_valid = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t d;
    logic [N-1:0] on;
    logic [SHW-1:0] sh;

    rst = 1'b1;
    bus.sample_tick_in = 1'b0;
    bus.osc_is_on_in   = '0;
    bus.osc_data_in    = '0;
    bus.shift_in       = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_data",  32'(bus.mix_data_out), 32'd0);
    check_eq("rst_valid", 32'(bus.mix_valid_out), 32'd0);
    check_eq("rst_busy",  32'(bus.busy_out), 32'd0);
    check_eq("rst_ovr",   32'(bus.overrun_count_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic mix with cycle-exact latency and pulse width.
    send(mk(16'd1000, 16'd2000, 16'd3000, 16'd4000), 4'hF, 4'd0, 16'h2710);
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) @(negedge clk);
      check_eq($sformatf("lat_valid_e%0d", i), 32'(bus.mix_valid_out), 32'(i == 5));
      check_eq($sformatf("lat_busy_e%0d", i), 32'(bus.busy_out), 32'(i < 5));
    end
    @(negedge clk);
    check_eq("valid_width", 32'(bus.mix_valid_out), 32'd0);
    check_eq("data_hold", 32'(bus.mix_data_out), 32'h2710);

    // Saturation and shift rounding.
    send(mk(16'h7000, 16'h7000, 16'h7000, 16'h7000), 4'hF, 4'd0, 16'h7FFF); wait_idle();
    send(mk(16'h9000, 16'h9000, 16'h9000, 16'h9000), 4'hF, 4'd0, 16'h8000); wait_idle();
    send(mk(16'h7000, 16'h7000, 16'h7000, 16'h7000), 4'hF, 4'd2, 16'h7000); wait_idle();
    send(mk(16'hFFFD, 16'h0000, 16'h0000, 16'h0000), 4'hF, 4'd1, 16'hFFFE); wait_idle();

    // Enables.
    send(mk(16'd100, 16'd200, 16'd300, 16'd400), 4'b1010, 4'd0, 16'd600); wait_idle();
    send(mk(16'h1234, 16'h5678, 16'h0F0F, 16'h7777), 4'b0000, 4'd0, 16'd0); wait_idle();

    // Random vectors against the model.
    for (int k = 0; k < 8; k++) begin
      d  = vec_t'({$urandom(), $urandom()});
      on = N'($urandom());
      sh = SHW'($urandom_range(0, 3));
      send(d, on, sh, model(d, on, sh));
      wait_idle();
    end

    // Back-to-back ticks every N+1 cycles.
    b2b_chk = 1'b1;
    last_valid = -1;
    for (int k = 0; k < 6; k++) begin
      d  = vec_t'({$urandom(), $urandom()});
      on = N'($urandom());
      sh = SHW'($urandom_range(0, 2));
      send(d, on, sh, model(d, on, sh));
      repeat (4) begin
        check_eq("b2b_busy", 32'(bus.busy_out), 32'd1);
        @(negedge clk);
      end
    end
    wait_idle();
    b2b_chk = 1'b0;
    check_eq("b2b_ovr", 32'(bus.overrun_count_out), 32'd0);

    // Single overrun: second tick lands in ACCUM and is dropped.
    send(mk(16'd11, 16'd22, 16'd33, 16'd44), 4'hF, 4'd0, 16'd110);
    @(negedge clk);
    bus.sample_tick_in = 1'b1;
    @(negedge clk);
    bus.sample_tick_in = 1'b0;
    wait_idle();
    check_eq("ovr_one", 32'(bus.overrun_count_out), 32'd1);

    // Continuous tick: many overruns, counter must stick at 255.
    mon_en = 1'b0;
    bus.sample_tick_in = 1'b1;
    repeat (400) @(negedge clk);
    bus.sample_tick_in = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check_eq("ovr_sat", 32'(bus.overrun_count_out), 32'd255);

    // Reset during ACCUM aborts the mix.
    send(mk(16'd5, 16'd5, 16'd5, 16'd5), 4'hF, 4'd0, 16'd20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check_eq("abort_data",  32'(bus.mix_data_out), 32'd0);
    check_eq("abort_valid", 32'(bus.mix_valid_out), 32'd0);
    check_eq("abort_busy",  32'(bus.busy_out), 32'd0);
    check_eq("abort_ovr",   32'(bus.overrun_count_out), 32'd0);
    repeat (8) @(negedge clk);
    check_eq("abort_idle", 32'(bus.busy_out), 32'd0);
    send(mk(16'd1, 16'd1, 16'd1, 16'd1), 4'hF, 4'd0, 16'd4);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/osc_mixer.md
Name: osc_mixer

Overview:
- Sits directly downstream of the wave loader's per-oscillator sample outputs and upstream of the audio output stage (PWM/I2S).
- On each audio sample strobe it snapshots every oscillator's current sample and on-flag. It then sums the enabled samples serially, one oscillator per clock.
- The sum is attenuated by a programmable arithmetic shift, saturated to SAMPLE_WIDTH, and presented as one mixed sample with a single-cycle valid pulse.

Parameters:
- NUM_OSCILLATORS, 4: number of oscillator inputs mixed; must be >= 1.
- SAMPLE_WIDTH, 16: width of input and output samples; signed two's complement.
- SHIFT_WIDTH, 4: width of the attenuation shift control.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- sample_tick_in  input  1  one-cycle audio sample-rate strobe
- osc_is_on_in  input  NUM_OSCILLATORS  per-oscillator enable
- osc_data_in  input  NUM_OSCILLATORS x SAMPLE_WIDTH  per-oscillator sample (packed array, as produced by the wave loader)
- shift_in  input  SHIFT_WIDTH  attenuation; result = sum >>> shift_in
- mix_data_out  output  SAMPLE_WIDTH  mixed, saturated sample
- mix_valid_out  output  1  one-cycle pulse when mix_data_out updates
- busy_out  output  1  high while a mix is in progress (ACCUM or OUTPUT)
- overrun_count_out  output  8  count of dropped ticks; saturates at 255

Behaviour:
- Clock and reset:
  - One clock domain: clk_in.
  - rst_in is synchronous and active-high.
  - Reset values: mix_data_out=0, mix_valid_out=0, busy_out=0, overrun_count_out=0, state=IDLE, accumulator=0, oscillator index=0.
  - Reset asserted mid-operation aborts the mix; no valid pulse is emitted for the aborted tick.
- States: IDLE, ACCUM, OUTPUT.
- IDLE:
  - On sample_tick_in: register snapshots of osc_data_in, osc_is_on_in and shift_in; clear the accumulator; set index=0; go to ACCUM.
  - Inputs change every cycle upstream (time-multiplexed), so only the snapshots are used afterwards.
- ACCUM (exactly NUM_OSCILLATORS cycles):
  - Each cycle: acc += on_snap[index] ? sign_extend(data_snap[index]) : 0; index++.
  - After index NUM_OSCILLATORS-1 is accumulated, go to OUTPUT.
  - Accumulator width is SAMPLE_WIDTH + clog2(NUM_OSCILLATORS) + 1; it never overflows.
- OUTPUT (1 cycle):
  - scaled = acc >>> shift_snap. The shift is arithmetic and floors toward -inf (e.g. -3 >>> 1 = -2).
  - Saturate to the signed SAMPLE_WIDTH range: max 0x7FFF, min 0x8000 for width 16.
  - At the edge leaving OUTPUT: register mix_data_out and pulse mix_valid_out high for exactly the next cycle.
  - If sample_tick_in is high in OUTPUT, the same edge also takes a new snapshot and goes to ACCUM (back-to-back). Otherwise go to IDLE.
- Latency and throughput:
  - mix_valid_out is high in the cycle that begins NUM_OSCILLATORS+1 edges after the edge that sampled the tick.
  - Minimum tick period is NUM_OSCILLATORS+1 cycles.
- Overrun:
  - A tick arriving in ACCUM is dropped and increments overrun_count_out (saturating at 255).
  - A dropped tick does not disturb the mix in progress.
- Other output rules:
  - mix_data_out holds its value between valid pulses.
  - If all oscillators are off, the result is 0 and mix_valid_out still pulses.
  - busy_out = (state != IDLE). It stays high through back-to-back operation.

Test Plan:
- N=4, all on, data {1000,2000,3000,4000}, shift 0, tick at edge E0 -> mix_data_out=10000 (0x2710), mix_valid_out high for exactly one cycle after edge E5, busy_out high from E0 to E5.
- Saturation:
  - Four samples 0x7000, shift 0 -> 0x7FFF.
  - Four samples 0x9000, shift 0 -> 0x8000.
  - Four samples 0x7000, shift 2 -> 0x7000.
  - Samples {-3,0,0,0}, shift 1 -> 0xFFFE (-2).
- Enables: data {100,200,300,400}, osc_is_on={0,1,0,1} (osc1, osc3 on) -> 600. All off -> 0 with a valid pulse. Data changed on the cycle after the tick -> result unaffected (snapshot).
- Overrun: tick, then a second tick 2 cycles later (in ACCUM) -> one valid pulse with the first result, overrun_count_out=1. Drive 300 overrun ticks -> count holds 255.
- Back-to-back: ticks every 5 cycles (N=4) -> valid every 5 cycles, busy_out never drops, overrun_count_out stays 0.
- Reset: rst_in for 1 cycle during ACCUM -> next cycle mix_data_out=0, mix_valid_out=0, busy_out=0, no pulse for the aborted tick. A following tick with data {1,1,1,1} -> 4.
